// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared size codes, FSM state type and load extension helper
package mem_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic {IDLE, WAIT} state_e;

   // Pick the addressed byte/half out of the RAM word and widen it to 32 bits.
   function automatic logic [31:0] fn_extend(input logic [31:0] word,
                                             input logic [1:0]  lane,
                                             input logic [1:0]  size,
                                             input logic        is_unsigned);
      logic [7:0]  b;
      logic [15:0] h;
      b = word[{lane, 3'b000} +: 8];
      h = word[{lane[1], 4'b0000} +: 16];
      case (size)
         SZ_BYTE: fn_extend = is_unsigned ? {24'd0, b} : {{24{b[7]}}, b};
         SZ_HALF: fn_extend = is_unsigned ? {16'd0, h} : {{16{h[15]}}, h};
         default: fn_extend = word;
      endcase
   endfunction

endpackage

// File: rtl/mem_stage_param_if.sv
// rtl/mem_stage_param_if.sv - EXE-side inputs, stall and MEM/WB outputs of the memory stage
interface mem_stage_param_if #(parameter int REG_W = 5);

   logic             wb_en_exe;
   logic             mem_r_en_exe;
   logic             mem_w_en_exe;
   logic [1:0]       size_exe;
   logic             unsigned_exe;
   logic [REG_W-1:0] dest_exe;
   logic [31:0]      alu_result_exe;
   logic [31:0]      store_data_exe;

   logic             stall;
   logic             wb_en_mem;
   logic             mem_r_en_mem;
   logic [REG_W-1:0] dest_mem;
   logic [31:0]      alu_result_mem;
   logic [31:0]      load_data_mem;
   logic             fault_mem;

   modport master (
      output wb_en_exe, mem_r_en_exe, mem_w_en_exe, size_exe, unsigned_exe,
             dest_exe, alu_result_exe, store_data_exe,
      input  stall, wb_en_mem, mem_r_en_mem, dest_mem, alu_result_mem,
             load_data_mem, fault_mem
   );

   modport slave (
      input  wb_en_exe, mem_r_en_exe, mem_w_en_exe, size_exe, unsigned_exe,
             dest_exe, alu_result_exe, store_data_exe,
      output stall, wb_en_mem, mem_r_en_mem, dest_mem, alu_result_mem,
             load_data_mem, fault_mem
   );

endinterface

// File: rtl/data_mem_bank.sv
// rtl/data_mem_bank.sv - DEPTH x 32 data RAM, byte-enable synchronous write, asynchronous read
module data_mem_bank #(
   parameter int DEPTH = 64,
   parameter int IW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we_i,
   input  logic [3:0]    be_i,
   input  logic [IW-1:0] addr_i,
   input  logic [31:0]   wdata_i,
   output logic [31:0]   rdata_o
);

   logic [31:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we_i) begin
         for (int i = 0; i < 4; i++) begin
            if (be_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
         end
      end
   end

   assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/mem_stage_param.sv
// rtl/mem_stage_param.sv - MIPS MEM stage: address decode, faults, wait-state FSM, MEM/WB register
module mem_stage_param
   import mem_pkg::*;
#(
   parameter int          DEPTH       = 64,
   parameter logic [31:0] BASE_ADDR   = 32'd1024,
   parameter int          WAIT_STATES = 0,
   parameter int          REG_W       = 5
) (
   input logic              clk,
   input logic              rst,
   mem_stage_param_if.slave bus
);

   localparam int          IW   = $clog2(DEPTH);
   localparam logic [31:0] SPAN = 32'(4 * DEPTH);
   localparam logic [3:0]  WS   = 4'(WAIT_STATES);

   logic [31:0]      off;
   logic [1:0]       lane;
   logic [IW-1:0]    widx;
   logic [1:0]       size_n;
   logic             is_mem;
   logic             out_of_range;
   logic             misaligned;
   logic             fault;
   logic [3:0]       be;
   logic [31:0]      wdata;
   logic [31:0]      rdata;
   logic             we;
   logic             stall;
   logic [31:0]      load_d;

   state_e           state_q;
   logic [3:0]       cnt_q;
   logic             wb_en_q;
   logic             mem_r_en_q;
   logic [REG_W-1:0] dest_q;
   logic [31:0]      alu_result_q;
   logic [31:0]      load_data_q;
   logic             fault_q;

   // Addresses below the base wrap to huge offsets, so one unsigned compare covers both ends.
   always_comb begin
      off          = bus.alu_result_exe - BASE_ADDR;
      lane         = off[1:0];
      widx         = off[IW+1:2];
      size_n       = (bus.size_exe == 2'b11) ? SZ_WORD : bus.size_exe;
      is_mem       = bus.mem_r_en_exe || bus.mem_w_en_exe;
      out_of_range = (off >= SPAN);
      misaligned   = ((size_n == SZ_HALF) && lane[0]) ||
                     ((size_n == SZ_WORD) && (lane != 2'b00));
      fault        = is_mem && (out_of_range || misaligned);
      be           = 4'b1111;
      wdata        = bus.store_data_exe;
      case (size_n)
         SZ_BYTE: begin
            be    = 4'b0001 << lane;
            wdata = {4{bus.store_data_exe[7:0]}};
         end
         SZ_HALF: begin
            be    = 4'b0011 << lane;
            wdata = {2{bus.store_data_exe[15:0]}};
         end
         default: be = 4'b1111;
      endcase
   end

   assign stall = (WAIT_STATES != 0) && is_mem &&
                  ((state_q == IDLE) || (cnt_q != 4'd0));
   assign we    = bus.mem_w_en_exe && !fault && !stall && !rst;

   data_mem_bank #(.DEPTH(DEPTH), .IW(IW)) u_bank (
      .clk     (clk),
      .we_i    (we),
      .be_i    (be),
      .addr_i  (widx),
      .wdata_i (wdata),
      .rdata_o (rdata)
   );

   // Read happens before the same-edge write, so load+store returns the old word.
   assign load_d = (bus.mem_r_en_exe && !fault) ?
                   fn_extend(rdata, lane, size_n, bus.unsigned_exe) : 32'd0;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
      end else begin
         case (state_q)
            IDLE: begin
               if (stall) begin
                  state_q <= WAIT;
                  cnt_q   <= WS - 4'd1;
               end
            end
            WAIT: begin
               if (cnt_q != 4'd0) cnt_q   <= cnt_q - 4'd1;
               else               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst || stall) begin
         wb_en_q      <= 1'b0;
         mem_r_en_q   <= 1'b0;
         dest_q       <= '0;
         alu_result_q <= 32'd0;
         load_data_q  <= 32'd0;
         fault_q      <= 1'b0;
      end else begin
         wb_en_q      <= bus.wb_en_exe;
         mem_r_en_q   <= bus.mem_r_en_exe;
         dest_q       <= bus.dest_exe;
         alu_result_q <= bus.alu_result_exe;
         load_data_q  <= load_d;
         fault_q      <= fault;
      end
   end

   assign bus.stall          = stall;
   assign bus.wb_en_mem      = wb_en_q;
   assign bus.mem_r_en_mem   = mem_r_en_q;
   assign bus.dest_mem       = dest_q;
   assign bus.alu_result_mem = alu_result_q;
   assign bus.load_data_mem  = load_data_q;
   assign bus.fault_mem      = fault_q;

endmodule

// File: tb/tb_mem_stage_param.sv
// tb/tb_mem_stage_param.sv - scoreboard bench for mem_stage_param with 0 and 3 wait states
module tb_mem_stage_param;

   typedef struct packed {
      logic        w;
      logic        r;
      logic [1:0]  size;
      logic        uns;
      logic        wb;
      logic [4:0]  dest;
      logic [31:0] alu;
      logic [31:0] sd;
   } ins_t;

   typedef struct packed {
      logic        wb;
      logic        r;
      logic [4:0]  dest;
      logic [31:0] alu;
      logic [31:0] ld;
      logic        f;
   } exp_t;

   logic clk = 1'b0;
   logic rst0, rst3;
   always #5 clk = ~clk;

   mem_stage_param_if #(.REG_W(5)) b0 ();
   mem_stage_param_if #(.REG_W(5)) b3 ();

   mem_stage_param #(.WAIT_STATES(0)) u0 (.clk(clk), .rst(rst0), .bus(b0));
   mem_stage_param #(.WAIT_STATES(3)) u3 (.clk(clk), .rst(rst3), .bus(b3));

   ins_t ins0, ins3;

   assign b0.wb_en_exe      = ins0.wb;
   assign b0.mem_r_en_exe   = ins0.r;
   assign b0.mem_w_en_exe   = ins0.w;
   assign b0.size_exe       = ins0.size;
   assign b0.unsigned_exe   = ins0.uns;
   assign b0.dest_exe       = ins0.dest;
   assign b0.alu_result_exe = ins0.alu;
   assign b0.store_data_exe = ins0.sd;

   assign b3.wb_en_exe      = ins3.wb;
   assign b3.mem_r_en_exe   = ins3.r;
   assign b3.mem_w_en_exe   = ins3.w;
   assign b3.size_exe       = ins3.size;
   assign b3.unsigned_exe   = ins3.uns;
   assign b3.dest_exe       = ins3.dest;
   assign b3.alu_result_exe = ins3.alu;
   assign b3.store_data_exe = ins3.sd;

   int   checks = 0;
   int   errors = 0;
   exp_t q0[$];
   exp_t q3[$];
   int   issued0 = 0, popped0 = 0, issued3 = 0, popped3 = 0;
   logic pv0 = 1'b0, ps0, pr0, pend0;
   logic pv3 = 1'b0, ps3, pr3, pend3;

   function automatic ins_t mk(input logic w, input logic r, input logic [1:0] sz,
                               input logic uns, input logic wb, input logic [4:0] d,
                               input logic [31:0] a, input logic [31:0] sd);
      mk = '{w: w, r: r, size: sz, uns: uns, wb: wb, dest: d, alu: a, sd: sd};
   endfunction

   function automatic exp_t ex(input logic wb, input logic r, input logic [4:0] d,
                               input logic [31:0] a, input logic [31:0] ld, input logic f);
      ex = '{wb: wb, r: r, dest: d, alu: a, ld: ld, f: f};
   endfunction

   task automatic check_out(input int idx, input logic ps, input logic pr,
                            input logic pend, input exp_t act);
      exp_t e;
      if (pr) begin
         checks++;
         if (act !== '0) begin
            errors++;
            $display("FAIL reset_state u%0d act=%h exp=0", idx, act);
         end
      end else if (ps) begin
         checks++;
         if (act !== '0) begin
            errors++;
            $display("FAIL bubble u%0d act=%h exp=0", idx, act);
         end
      end else if (pend) begin
         if (idx == 0 && q0.size() != 0) begin
            e = q0.pop_front();
            popped0++;
         end else if (idx == 3 && q3.size() != 0) begin
            e = q3.pop_front();
            popped3++;
         end else begin
            e = 'x;
         end
         checks++;
         if (act !== e) begin
            errors++;
            $display("FAIL result u%0d act=%h exp=%h", idx, act, e);
         end
      end
   endtask

   always begin
      @(negedge clk);
      #2;
      if (pv0) check_out(0, ps0, pr0, pend0,
         {b0.wb_en_mem, b0.mem_r_en_mem, b0.dest_mem, b0.alu_result_mem,
          b0.load_data_mem, b0.fault_mem});
      ps0   = b0.stall;
      pr0   = rst0;
      pend0 = (issued0 > popped0);
      pv0   = 1'b1;
   end

   always begin
      @(negedge clk);
      #2;
      if (pv3) check_out(3, ps3, pr3, pend3,
         {b3.wb_en_mem, b3.mem_r_en_mem, b3.dest_mem, b3.alu_result_mem,
          b3.load_data_mem, b3.fault_mem});
      ps3   = b3.stall;
      pr3   = rst3;
      pend3 = (issued3 > popped3);
      pv3   = 1'b1;
   end

   task automatic issue(input int idx, input ins_t i, input exp_t e, output int n);
      @(negedge clk);
      if (idx == 0) begin
         ins0 = i;
         q0.push_back(e);
         issued0++;
      end else begin
         ins3 = i;
         q3.push_back(e);
         issued3++;
      end
      #1;
      n = 0;
      while (((idx == 0) ? b0.stall : b3.stall) && n < 50) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (n >= 50) begin
         checks++;
         errors++;
         $display("FAIL stall_timeout u%0d act=%0d exp<50", idx, n);
      end
   endtask

   task automatic chk_n(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s act=%0d exp=%0d", name, act, exp);
      end
   endtask

   initial begin
      int n;
      rst0 = 1'b1;
      rst3 = 1'b1;
      ins0 = '0;
      ins3 = '0;
      repeat (3) @(negedge clk);
      rst0 = 1'b0;
      rst3 = 1'b0;
      #1;
      chk_n("stall_after_reset", int'(b3.stall), 0);

      issue(0, mk(1,0,2,0,0,0,1028,32'hDEADBEEF), ex(0,0,0,1028,0,0), n);
      issue(0, mk(0,1,2,0,1,2,1028,0), ex(1,1,2,1028,32'hDEADBEEF,0), n);
      chk_n("ws0_no_stall", n, 0);
      issue(0, mk(1,0,2,0,0,0,1024,32'h11223344), ex(0,0,0,1024,0,0), n);
      issue(0, mk(1,0,0,0,0,0,1025,32'h123456AA), ex(0,0,0,1025,0,0), n);
      issue(0, mk(0,1,2,0,1,3,1024,0), ex(1,1,3,1024,32'h1122AA44,0), n);
      issue(0, mk(0,1,0,0,1,4,1025,0), ex(1,1,4,1025,32'hFFFFFFAA,0), n);
      issue(0, mk(0,1,0,1,1,5,1025,0), ex(1,1,5,1025,32'h000000AA,0), n);
      issue(0, mk(0,1,1,0,1,6,1026,0), ex(1,1,6,1026,32'h00001122,0), n);
      issue(0, mk(0,1,1,0,1,6,1024,0), ex(1,1,6,1024,32'hFFFFAA44,0), n);
      issue(0, mk(0,1,2,0,1,8,1026,0), ex(1,1,8,1026,0,1), n);
      issue(0, mk(1,0,2,0,0,0,1276,32'h55AA55AA), ex(0,0,0,1276,0,0), n);
      issue(0, mk(1,0,2,0,0,0,1020,32'h00000099), ex(0,0,0,1020,0,1), n);
      issue(0, mk(0,1,2,0,1,9,1276,0), ex(1,1,9,1276,32'h55AA55AA,0), n);
      issue(0, mk(1,0,2,0,0,0,1280,32'h00000077), ex(0,0,0,1280,0,1), n);
      issue(0, mk(0,1,2,0,1,10,1024,0), ex(1,1,10,1024,32'h1122AA44,0), n);
      issue(0, mk(0,1,3,0,1,11,1028,0), ex(1,1,11,1028,32'hDEADBEEF,0), n);
      issue(0, mk(1,0,2,0,0,0,1032,32'hCAFEF00D), ex(0,0,0,1032,0,0), n);
      issue(0, mk(1,1,2,0,1,12,1032,32'h12345678), ex(1,1,12,1032,32'hCAFEF00D,0), n);
      issue(0, mk(0,1,2,0,1,13,1032,0), ex(1,1,13,1032,32'h12345678,0), n);
      issue(0, mk(1,0,1,0,0,0,1034,32'h9999BEEF), ex(0,0,0,1034,0,0), n);
      issue(0, mk(0,1,2,0,1,13,1032,0), ex(1,1,13,1032,32'hBEEF5678,0), n);
      issue(0, mk(0,0,0,0,1,7,32'h42,0), ex(1,0,7,32'h42,0,0), n);
      issue(0, mk(0,1,0,1,1,15,1280,0), ex(1,1,15,1280,0,1), n);
      issue(0, '0, '0, n);

      issue(3, mk(1,0,2,0,0,0,1028,32'hDEADBEEF), ex(0,0,0,1028,0,0), n);
      chk_n("ws3_store_stall", n, 3);
      issue(3, mk(0,1,2,0,1,2,1028,0), ex(1,1,2,1028,32'hDEADBEEF,0), n);
      chk_n("ws3_load_stall", n, 3);
      issue(3, mk(0,0,0,0,1,7,32'h42,0), ex(1,0,7,32'h42,0,0), n);
      chk_n("ws3_add_no_stall", n, 0);
      issue(3, mk(1,0,2,0,0,0,1032,32'h00001111), ex(0,0,0,1032,0,0), n);

      @(negedge clk);
      ins3 = mk(1,0,2,0,0,0,1032,32'h00000005);
      @(negedge clk);
      rst3 = 1'b1;
      @(negedge clk);
      rst3 = 1'b0;
      ins3 = '0;
      #1;
      chk_n("stall_after_abort", int'(b3.stall), 0);

      issue(3, mk(0,1,2,0,1,9,1032,0), ex(1,1,9,1032,32'h00001111,0), n);
      chk_n("ws3_load_after_abort_stall", n, 3);
      issue(3, mk(0,1,2,0,1,3,1026,0), ex(1,1,3,1026,0,1), n);
      chk_n("ws3_fault_stall", n, 3);
      issue(3, '0, '0, n);

      repeat (4) @(negedge clk);
      #5;
      chk_n("queues_drained", q0.size() + q3.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_stage_param.md
# mem_stage_param

Parametrised MIPS memory pipeline stage sitting between EXE and WB. It maps the EXE address into a local data RAM and performs byte, half and word loads and stores with sign or zero extension. Misaligned and out-of-range accesses are detected and suppressed. A configurable wait-state FSM stalls the pipeline for slow memory, and the stage registers results into the MEM/WB pipeline register.

## Interface
- `DEPTH`, default 64: data RAM words (power of 2, ≥4); word index width `IW = log2(DEPTH)`.
- `BASE_ADDR`, default 1024: byte address of RAM word 0.
- `WAIT_STATES`, default 0: extra cycles per memory access, 0..15.
- `REG_W`, default 5: destination register index width.
- Data width is fixed at 32 bits with 4 byte lanes.
- Reset and clock: reset `rst`, synchronous, active-high; clock `clk`.
- `rst`: input, 1 bit, synchronous reset.
- `clk`: input, 1 bit, clock.
- `wb_en_exe`: input, 1 bit, writeback enable from EXE.
- `mem_r_en_exe`: input, 1 bit, load request.
- `mem_w_en_exe`: input, 1 bit, store request.
- `size_exe`: input, 2 bits, access size: 00 byte, 01 half, 10 word, 11 treated as word.
- `unsigned_exe`: input, 1 bit, zero-extend loads (lbu/lhu).
- `dest_exe`: input, REG_W bits, destination register.
- `alu_result_exe`: input, 32 bits, effective byte address or ALU result.
- `store_data_exe`: input, 32 bits, store data; the low bits are used for byte/half stores.
- `stall`: output, 1 bit, combinational; upstream must hold all `*_exe` inputs stable while high.
- `wb_en_mem`, `mem_r_en_mem`: outputs, 1 bit each, registered.
- `dest_mem`: output, REG_W bits, registered.
- `alu_result_mem`, `load_data_mem`: outputs, 32 bits each, registered.
- `fault_mem`: output, 1 bit, registered; the access was misaligned or out of range.

## Operation
- Address map: `off = alu_result_exe - BASE_ADDR` (32-bit modulo). Word index is `off[IW+1:2]`; byte lane is `off[1:0]`.
- Out of range: `off >= 4*DEPTH`, unsigned. Addresses below `BASE_ADDR` wrap large and are therefore out of range.
- Misaligned: half access with `lane[0]=1`, or word access with `lane!=0`.
- A fault (either condition, on a load or store) suppresses the write, forces the load data to 0 and sets `fault_mem`. `wb_en_mem` still passes through; the hazard or exception unit acts on `fault_mem`.
- Stores use byte enables:
  - byte: lane `lane` ← `store_data[7:0]`.
  - half: lanes `lane`, `lane+1` ← `store_data[15:0]`.
  - word: all lanes.
  - Untouched lanes are preserved.
- Loads read asynchronously, extract the lane, then sign-extend, or zero-extend if `unsigned_exe`.
- Load and store asserted together: the store is performed, and the load data is the pre-write contents.
- Non-memory instructions pass through in one cycle, never stall, and set `load_data` to 0 and `fault` to 0.
- Wait-state FSM (only when `WAIT_STATES > 0`):
  - `IDLE`: if an access is present, assert `stall`, set `cnt ← WAIT_STATES-1`, go to `WAIT`.
  - `WAIT`: if `cnt != 0`, assert `stall` and decrement `cnt`. If `cnt == 0`, deassert `stall`, perform the RAM write and capture results, return to `IDLE`.
  - While `stall=1` the MEM/WB register captures a bubble: all outputs 0.
- With `WAIT_STATES=0` the FSM stays in `IDLE` and `stall` is constantly 0.
- Back-to-back accesses: the next access enters `IDLE` on the cycle after completion and stalls again.

## Timing
- Latency is 1 cycle without waits. A memory access occupies `WAIT_STATES+1` cycles, with `stall` high for the first `WAIT_STATES` of them.
- The RAM is written exactly once per store, on the rising edge of the completing cycle.
- Reset values:
  - `wb_en_mem`=0, `mem_r_en_mem`=0, `dest_mem`=0, `alu_result_mem`=0, `load_data_mem`=0, `fault_mem`=0.
  - FSM in `IDLE`, `cnt`=0, `stall`=0 on the cycle following reset.
- RAM contents are not reset.
- `rst` during `WAIT` aborts the access: no write is committed, and outputs follow reset values.
- `rst` has priority over all other inputs.

## Structure
- Package `mem_pkg`:
  - size codes `SZ_BYTE`=2'b00, `SZ_HALF`=2'b01, `SZ_WORD`=2'b10;
  - FSM state enum `{IDLE, WAIT}`;
  - function `fn_extend(word, lane, size, unsigned)`.
- Sub-module `data_mem_bank`: `DEPTH`×32 array, 4-bit byte-enable synchronous write, asynchronous read.
- The top level holds address decode, fault logic, the FSM and the MEM/WB register.

## Test plan
- Defaults, word round trip: `sw 0xDEADBEEF @1028`, then `lw @1028`. The next cycle gives `load_data_mem`=0xDEADBEEF, `fault_mem`=0.
- Byte and half lanes:
  - `sw 0x11223344 @1024`; `sb 0xAA @1025` → `lw` gives 0x1122AA44.
  - `lb @1025` → 0xFFFFFFAA.
  - `lbu @1025` → 0x000000AA.
  - `lh @1026` → 0x00001122.
- Faults:
  - `lw @1026` → `fault_mem`=1, `load_data_mem`=0.
  - `sw @1020` (below base) → `fault`, RAM unchanged.
  - `sw @1024+256` with DEPTH=64 → `fault`, RAM unchanged.
- WAIT_STATES=3: `lw @1028` → `stall` high for cycles 0-2 with bubble outputs; the result is registered at the end of cycle 3. A following `add` passes with no stall.
- Reset mid-wait: WAIT_STATES=3, `sw 0x5 @1032`, `rst` in cycle 1. A later `lw @1032` returns the old value, and `stall`=0 after reset.
- Pass-through: an `add` with `alu_result_exe`=0x42, `dest_exe`=7, `wb_en_exe`=1 → next cycle `alu_result_mem`=0x42, `dest_mem`=7, `wb_en_mem`=1, `mem_r_en_mem`=0.
